cic_interp: RTL

// Order-3 CIC interpolation filter: low-rate PCM in, high-rate samples out for the sigma-delta DAC path.

---
 rtl/cic_interp.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/cic_interp.sv
// Order-3 CIC interpolator, R = 2**filter_int_factor, unity gain; CIC_INTERP_SAT_EN saturates data_out instead of wrapping.
// Latency: a sample consumed on strobe k first reaches data_out on strobe k+3; data_out_valid pulses the cycle after each strobe.
// Backpressure: single holding register, data_in_ready = enable & ~hold_full; an empty hold at a phase-0 strobe sets sticky underrun.
module cic_interp #(
    parameter int INPUT_WIDTH       = 8,
    parameter int INPUT_FRAC_WIDTH  = 7,
    parameter int OUTPUT_WIDTH      = 8,
    parameter int OUTPUT_FRAC_WIDTH = 7,
    parameter int MAX_INT_RATE      = 8
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    clear,
    input  logic                    enable,
    input  logic [INPUT_WIDTH-1:0]  data_in,
    input  logic                    data_in_valid,
    output logic                    data_in_ready,
    input  logic [1:0]              filter_int_factor,
    input  logic                    out_strobe,
    output logic [OUTPUT_WIDTH-1:0] data_out,
    output logic                    data_out_valid,
    output logic                    underrun
);

    localparam int FW = INPUT_WIDTH + 9;
    localparam int S  = 6 + INPUT_FRAC_WIDTH - OUTPUT_FRAC_WIDTH;
    localparam int PW = (MAX_INT_RATE > 1) ? $clog2(MAX_INT_RATE) : 1;
    localparam logic signed [FW-1:0] OUT_MAX = FW'((2 ** (OUTPUT_WIDTH - 1)) - 1);
    localparam logic signed [FW-1:0] OUT_MIN = ~OUT_MAX;

    logic [INPUT_WIDTH-1:0]  hold;
    logic                    hold_full;
    logic [INPUT_WIDTH-1:0]  last;
    logic [PW-1:0]           phase;
    logic [1:0]              r_cur;
    logic signed [FW-1:0]    d1, d2, d3;
    logic signed [FW-1:0]    i0, i1, i2;

    logic                    phase0;
    logic                    accept;
    logic [1:0]              r_eff;
    logic [PW:0]             rate;
    logic [PW-1:0]           phase_max;
    logic [PW-1:0]           phase_nxt;
    logic [INPUT_WIDTH-1:0]  x_raw;
    logic signed [FW-1:0]    x_ext;
    logic signed [FW-1:0]    c1, c2, c3;
    logic signed [FW-1:0]    c3_sh;
    logic signed [FW-1:0]    u;
    logic signed [FW-1:0]    i2_sh;
    logic signed [FW-1:0]    rounded;
    logic [OUTPUT_WIDTH-1:0] out_nxt;

    assign data_in_ready = enable & ~hold_full;
    assign accept        = data_in_valid & data_in_ready;
    assign phase0        = (phase == '0);

    // A new factor is only picked up at the start of a period.
    assign r_eff     = phase0 ? filter_int_factor : r_cur;
    assign rate      = {{PW{1'b0}}, 1'b1} << r_eff;
    assign phase_max = PW'(rate - 1'b1);
    assign phase_nxt = (phase == phase_max) ? '0 : phase + PW'(1);

    assign x_raw = hold_full ? hold : last;
    assign x_ext = {{(FW - INPUT_WIDTH){x_raw[INPUT_WIDTH-1]}}, x_raw};
    assign c1    = x_ext - d1;
    assign c2    = c1 - d2;
    assign c3    = c2 - d3;

    // Pre-scale by 64/R^2 so every ratio ends up with the same gain of 64.
    always_comb begin
        c3_sh = c3;
        case (r_eff)
            2'd0:    c3_sh = c3 <<< 6;
            2'd1:    c3_sh = c3 <<< 4;
            2'd2:    c3_sh = c3 <<< 2;
            default: c3_sh = c3;
        endcase
    end

    assign u     = phase0 ? c3_sh : '0;
    assign i2_sh = i2 >>> S;

    generate
        if (S > 0) begin : g_round
            assign rounded = i2_sh + {{(FW - 1){1'b0}}, i2[S-1]};
        end else begin : g_noround
            assign rounded = i2_sh;
        end
    endgenerate

    always_comb begin
`ifdef CIC_INTERP_SAT_EN
        if (rounded > OUT_MAX)
            out_nxt = OUTPUT_WIDTH'(OUT_MAX);
        else if (rounded < OUT_MIN)
            out_nxt = OUTPUT_WIDTH'(OUT_MIN);
        else
            out_nxt = OUTPUT_WIDTH'(rounded);
`else
        out_nxt = OUTPUT_WIDTH'(rounded);
`endif
    end

    always_ff @(posedge clk) begin
        if (!resetn || clear) begin
            hold           <= '0;
            hold_full      <= 1'b0;
            last           <= '0;
            phase          <= '0;
            r_cur          <= '0;
            d1             <= '0;
            d2             <= '0;
            d3             <= '0;
            i0             <= '0;
            i1             <= '0;
            i2             <= '0;
            data_out       <= '0;
            data_out_valid <= 1'b0;
            underrun       <= 1'b0;
        end else begin
            data_out_valid <= 1'b0;
            if (enable) begin
                if (accept) begin
                    hold      <= data_in;
                    hold_full <= 1'b1;
                end
                if (out_strobe) begin
                    if (phase0) begin
                        if (!hold_full)
                            underrun <= 1'b1;
                        if (!accept)
                            hold_full <= 1'b0;
                        last  <= x_raw;
                        r_cur <= filter_int_factor;
                        d1    <= x_ext;
                        d2    <= c1;
                        d3    <= c2;
                    end
                    i0             <= i0 + u;
                    i1             <= i1 + i0;
                    i2             <= i2 + i1;
                    phase          <= phase_nxt;
                    data_out       <= out_nxt;
                    data_out_valid <= 1'b1;
                end
            end
        end
    end

endmodule
